pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage Y86-64 core. It samples stage-register contents and early datapath results, and drives the stall/bubble controls of the F, D, E, M and W pipeline registers, including the E→M register, plus the condition-code write enable. It owns a run/halt state machine that freezes the pipeline once an exceptional status retires. It also keeps saturating performance counters.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/sat_counter.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline control and stage registers.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Register id meaning "no register"
    localparam logic [3:0] REG_NONE = 4'hF;

    // Default performance counter width
    localparam int CNT_W_DEFAULT = 32;

    // True for any status that must stop the machine
    function automatic logic stat_is_exc(input logic [2:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Clear has priority; otherwise count up until the ceiling is reached
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc_en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble generation,
// run/halt state machine and saturating performance counters.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_r;
    logic       halted_r;
    logic [2:0] halt_stat_r;

    logic loaduse_s;
    logic mispred_s;
    logic ret_in_s;
    logic m_exc_s;
    logic w_exc_s;
    logic run_s;
    logic retire_s;
    logic cnt_clr_s;

    // Hazard terms derived from the current stage contents
    always_comb begin
        loaduse_s = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                    (E_dstM != REG_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred_s = (E_icode == I_JXX) && !e_Cnd;
        ret_in_s  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        m_exc_s   = stat_is_exc(m_stat);
        w_exc_s   = stat_is_exc(W_stat);
    end

    // Pipeline register controls; a load-use stall outranks the RET bubble in D
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (state_r)
            ST_RUN: begin
                F_stall  = loaduse_s || ret_in_s;
                D_stall  = loaduse_s;
                D_bubble = mispred_s || (ret_in_s && !loaduse_s);
                E_bubble = mispred_s || loaduse_s;
                M_bubble = m_exc_s || w_exc_s;
                W_stall  = w_exc_s;
                set_cc   = (E_icode == I_OPQ) && !m_exc_s && !w_exc_s;
            end
            ST_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
        endcase
    end

    // Run/halt sequencing; the halting status is captured on the edge it retires
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RESET;
            halted_r    <= 1'b0;
            halt_stat_r <= STAT_AOK;
        end else begin
            case (state_r)
                ST_RESET: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_exc_s) begin
                        state_r     <= ST_HALTED;
                        halted_r    <= 1'b1;
                        halt_stat_r <= W_stat;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_RESET;
                end
            endcase
        end
    end

    assign halted    = halted_r;
    assign halt_stat = halt_stat_r;

    // Counter enables: counting happens only while running
    always_comb begin
        run_s     = (state_r == ST_RUN);
        retire_s  = run_s && (W_stat == STAT_AOK) && (W_icode != I_NOP) && !W_stall;
        cnt_clr_s = !rst_n;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .clr    (cnt_clr_s),
        .inc_en (run_s),
        .cnt    (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk    (clk),
        .clr    (cnt_clr_s),
        .inc_en (retire_s),
        .cnt    (retired_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .clk    (clk),
        .clr    (cnt_clr_s),
        .inc_en (run_s && loaduse_s),
        .cnt    (loaduse_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk    (clk),
        .clr    (cnt_clr_s),
        .inc_en (run_s && mispred_s),
        .cnt    (mispred_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl with a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int W = 4;
    localparam int CMAX = 15;

    localparam int MODE_UNKNOWN = 0;
    localparam int MODE_RESET   = 1;
    localparam int MODE_RUN     = 2;
    localparam int MODE_HALTED  = 3;

    logic         clk;
    logic         rst_n;
    logic [3:0]   D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic         e_Cnd;
    logic [2:0]   m_stat, W_stat;
    logic         F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic         halted;
    logic [2:0]   halt_stat;
    logic [W-1:0] cycle_cnt, retired_cnt, loaduse_cnt, mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int m_mode = MODE_UNKNOWN;
    int m_cyc, m_ret, m_lu, m_mp;
    int m_halted;
    int m_hstat;

    pipe_hazard_ctrl #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .D_icode     (D_icode),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .E_icode     (E_icode),
        .E_dstM      (E_dstM),
        .e_Cnd       (e_Cnd),
        .M_icode     (M_icode),
        .m_stat      (m_stat),
        .W_stat      (W_stat),
        .W_icode     (W_icode),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .D_bubble    (D_bubble),
        .E_bubble    (E_bubble),
        .M_bubble    (M_bubble),
        .W_stall     (W_stall),
        .set_cc      (set_cc),
        .halted      (halted),
        .halt_stat   (halt_stat),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt),
        .loaduse_cnt (loaduse_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_exc(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    function automatic bit model_loaduse();
        bit is_load;
        is_load = (E_icode == 4'd5) || (E_icode == 4'd11);
        return is_load && (E_dstM != 4'd15) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic bit model_mispred();
        return (E_icode == 4'd7) && (e_Cnd == 1'b0);
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    function automatic logic [6:0] exp_ctrl();
        bit lu, mp, rt, ex_m, ex_w;
        if (m_mode == MODE_RESET)  return 7'b0011100;
        if (m_mode == MODE_HALTED) return 7'b1101110;
        lu   = model_loaduse();
        mp   = model_mispred();
        rt   = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        ex_m = is_exc(m_stat);
        ex_w = is_exc(W_stat);
        return {lu | rt, lu, mp | (rt & ~lu), mp | lu, ex_m | ex_w, ex_w,
                (E_icode == 4'd6) & ~ex_m & ~ex_w};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        if (!rst_n) begin
            m_mode = MODE_RESET;
            m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
            m_halted = 0;
            m_hstat = 1;
        end else if (m_mode == MODE_RESET) begin
            m_mode = MODE_RUN;
        end else if (m_mode == MODE_RUN) begin
            m_cyc = sat_inc(m_cyc);
            if (model_loaduse()) m_lu = sat_inc(m_lu);
            if (model_mispred()) m_mp = sat_inc(m_mp);
            if ((W_stat == 3'd1) && (W_icode != 4'd1)) m_ret = sat_inc(m_ret);
            if (is_exc(W_stat)) begin
                m_mode = MODE_HALTED;
                m_halted = 1;
                m_hstat = int'(W_stat);
            end
        end
    endtask

    task automatic tick();
        logic [6:0] e;
        @(negedge clk);
        if (m_mode != MODE_UNKNOWN) begin
            e = exp_ctrl();
            check_val("F_stall",  {31'd0, F_stall},  {31'd0, e[6]});
            check_val("D_stall",  {31'd0, D_stall},  {31'd0, e[5]});
            check_val("D_bubble", {31'd0, D_bubble}, {31'd0, e[4]});
            check_val("E_bubble", {31'd0, E_bubble}, {31'd0, e[3]});
            check_val("M_bubble", {31'd0, M_bubble}, {31'd0, e[2]});
            check_val("W_stall",  {31'd0, W_stall},  {31'd0, e[1]});
            check_val("set_cc",   {31'd0, set_cc},   {31'd0, e[0]});
        end
        @(posedge clk);
        model_edge();
        #1;
        check_val("halted",      {31'd0, halted},      m_halted);
        check_val("halt_stat",   {29'd0, halt_stat},   m_hstat);
        check_val("cycle_cnt",   {28'd0, cycle_cnt},   m_cyc);
        check_val("retired_cnt", {28'd0, retired_cnt}, m_ret);
        check_val("loaduse_cnt", {28'd0, loaduse_cnt}, m_lu);
        check_val("mispred_cnt", {28'd0, mispred_cnt}, m_mp);
    endtask

    task automatic set_idle();
        D_icode = 4'd1; d_srcA = 4'd15; d_srcB = 4'd15;
        E_icode = 4'd1; E_dstM = 4'd15; e_Cnd = 1'b1;
        M_icode = 4'd1; m_stat = 3'd1;
        W_stat = 3'd1;  W_icode = 4'd1;
    endtask

    function automatic logic [2:0] rand_stat();
        if ($urandom_range(0, 19) != 0) return 3'd1;
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        D_icode = 4'($urandom_range(0, 11));
        d_srcA  = 4'($urandom_range(0, 15));
        d_srcB  = 4'($urandom_range(0, 15));
        E_icode = 4'($urandom_range(0, 11));
        case ($urandom_range(0, 3))
            0:       E_dstM = d_srcA;
            1:       E_dstM = d_srcB;
            default: E_dstM = 4'($urandom_range(0, 15));
        endcase
        e_Cnd   = 1'($urandom_range(0, 1));
        M_icode = 4'($urandom_range(0, 11));
        m_stat  = rand_stat();
        W_stat  = rand_stat();
        W_icode = 4'($urandom_range(0, 11));
    endtask

    task automatic do_reset();
        rand_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        set_idle();
    endtask

    // Reset, then take the release edge so the core is in RUN with counters at 0
    task automatic start();
        do_reset();
        tick();
    endtask

    logic [W-1:0] sv_cyc, sv_ret, sv_lu, sv_mp;

    initial begin
        rst_n = 1'b0;
        set_idle();

        // 1: reset
        do_reset();
        check_val("rst_D_bubble", {31'd0, D_bubble}, 32'd1);
        check_val("rst_E_bubble", {31'd0, E_bubble}, 32'd1);
        check_val("rst_M_bubble", {31'd0, M_bubble}, 32'd1);
        check_val("rst_stalls", {29'd0, F_stall, D_stall, W_stall}, 32'd0);
        check_val("rst_halt_stat", {29'd0, halt_stat}, 32'd1);
        tick();
        tick();
        check_val("first_cycle_cnt", {28'd0, cycle_cnt}, 32'd1);

        // 2: load-use
        start();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        check_val("lu_ctrl", {28'd0, F_stall, D_stall, E_bubble, D_bubble}, 32'b1110);
        tick();
        check_val("lu_cnt", {28'd0, loaduse_cnt}, 32'd1);
        E_dstM = 4'd15; d_srcA = 4'd15;
        #1;
        check_val("lu_none_ctrl", {28'd0, F_stall, D_stall, E_bubble, D_bubble}, 32'd0);
        tick();

        // 3: mispredict
        start();
        E_icode = 4'd7; e_Cnd = 1'b0;
        #1;
        check_val("mp_ctrl", {29'd0, D_bubble, E_bubble, F_stall}, 32'b110);
        tick();
        check_val("mp_cnt", {28'd0, mispred_cnt}, 32'd1);
        e_Cnd = 1'b1;
        #1;
        check_val("mp_taken_ctrl",
                  {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, 32'd0);
        tick();

        // 4: RET with load-use
        start();
        D_icode = 4'd9; E_icode = 4'd11; E_dstM = 4'd4; d_srcB = 4'd4;
        #1;
        check_val("ret_lu_ctrl", {28'd0, F_stall, D_stall, D_bubble, E_bubble}, 32'b1101);
        tick();
        E_icode = 4'd1;
        #1;
        check_val("ret_ctrl", {30'd0, D_bubble, D_stall}, 32'b10);
        tick();

        // 5: exception and halt
        start();
        E_icode = 4'd6; m_stat = 3'd3;
        #1;
        check_val("mexc_ctrl", {30'd0, M_bubble, set_cc}, 32'b10);
        tick();
        E_icode = 4'd1; m_stat = 3'd1; W_stat = 3'd3; W_icode = 4'd4;
        #1;
        check_val("wexc_W_stall", {31'd0, W_stall}, 32'd1);
        tick();
        check_val("halt_flag", {31'd0, halted}, 32'd1);
        check_val("halt_code", {29'd0, halt_stat}, 32'd3);
        sv_cyc = cycle_cnt; sv_ret = retired_cnt; sv_lu = loaduse_cnt; sv_mp = mispred_cnt;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            tick();
        end
        check_val("frozen_cnts", {16'd0, cycle_cnt, retired_cnt, loaduse_cnt, mispred_cnt},
                  {16'd0, sv_cyc, sv_ret, sv_lu, sv_mp});
        start();
        check_val("post_halt_cnts", {16'd0, cycle_cnt, retired_cnt, loaduse_cnt, mispred_cnt}, 32'd0);
        check_val("post_halt_run", {30'd0, halted, D_bubble}, 32'd0);

        // 6: saturation
        start();
        for (int i = 0; i < 20; i++) tick();
        check_val("cycle_sat", {28'd0, cycle_cnt}, 32'd15);
        W_stat = 3'd1; W_icode = 4'd6;
        for (int i = 0; i < 16; i++) tick();
        check_val("retired_sat", {28'd0, retired_cnt}, 32'd15);

        // random phase
        start();
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
